// File: rtl/bti_arbiter.sv
// ============================================================================
// Module   : bti_arbiter
// Brief    : Round-robin many-to-one BTI arbiter with in-order response routing
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module bti_arbiter #(
  parameter int BTI_AW   = 32,
  parameter int BTI_DW   = 32,
  parameter int HOST_NUM = 2,
  parameter int OUTSTD   = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  // host request ports (slave side)
  input  logic [HOST_NUM-1:0]        host_bti_req_vld,
  output logic [HOST_NUM-1:0]        host_bti_req_rdy,
  input  logic [HOST_NUM*BTI_AW-1:0] host_bti_req_addr,
  input  logic [HOST_NUM-1:0]        host_bti_req_cmd,
  input  logic [HOST_NUM*BTI_DW-1:0] host_bti_req_wdata,
  // host response ports (master side)
  output logic [HOST_NUM-1:0]        host_bti_rsp_vld,
  input  logic [HOST_NUM-1:0]        host_bti_rsp_rdy,
  output logic [HOST_NUM*BTI_DW-1:0] host_bti_rsp_data,
  // guest request port (master side)
  output logic                       gst_bti_req_vld,
  input  logic                       gst_bti_req_rdy,
  output logic [BTI_AW-1:0]          gst_bti_req_addr,
  output logic                       gst_bti_req_cmd,
  output logic [BTI_DW-1:0]          gst_bti_req_wdata,
  // guest response port (slave side)
  input  logic                       gst_bti_rsp_vld,
  output logic                       gst_bti_rsp_rdy,
  input  logic [BTI_DW-1:0]          gst_bti_rsp_data
);

  localparam int IW = (HOST_NUM > 1) ? $clog2(HOST_NUM) : 1;
  localparam int PW = $clog2(OUTSTD) + 1;

  logic [IW-1:0] rr;
  logic          lock;
  logic [IW-1:0] lock_idx;
  logic [IW-1:0] arb_idx;
  logic          arb_found;
  logic [IW-1:0] win;
  logic          win_vld;
  logic [IW-1:0] rr_nxt;
  logic          accept;

  logic [IW-1:0] id_mem [OUTSTD];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          fifo_full;
  logic          fifo_empty;
  logic [IW-1:0] head;
  logic          pop;

  // ---------------------------------------------------------------- arbitration
  always_comb begin
    int k;
    k         = 0;
    arb_idx   = rr;
    arb_found = 1'b0;
    for (int i = 0; i < HOST_NUM; i++) begin
      k = int'(rr) + i;
      if (k >= HOST_NUM) k = k - HOST_NUM;
      if (!arb_found && host_bti_req_vld[k]) begin
        arb_found = 1'b1;
        arb_idx   = IW'(k);
      end
    end
  end

  // A stalled request keeps its winner so the guest sees a stable payload.
  assign win    = lock ? lock_idx : arb_idx;
  assign rr_nxt = (win == IW'(HOST_NUM - 1)) ? '0 : win + IW'(1);

  always_comb begin
    win_vld           = 1'b0;
    gst_bti_req_addr  = '0;
    gst_bti_req_cmd   = 1'b0;
    gst_bti_req_wdata = '0;
    for (int i = 0; i < HOST_NUM; i++) begin
      if (IW'(i) == win) begin
        win_vld           = host_bti_req_vld[i];
        gst_bti_req_addr  = host_bti_req_addr[i*BTI_AW +: BTI_AW];
        gst_bti_req_cmd   = host_bti_req_cmd[i];
        gst_bti_req_wdata = host_bti_req_wdata[i*BTI_DW +: BTI_DW];
      end
    end
  end

  assign gst_bti_req_vld = win_vld && !fifo_full && !rst;
  assign accept          = gst_bti_req_vld && gst_bti_req_rdy;

  always_comb begin
    host_bti_req_rdy = '0;
    for (int i = 0; i < HOST_NUM; i++) begin
      host_bti_req_rdy[i] = (IW'(i) == win) && win_vld && gst_bti_req_rdy &&
                            !fifo_full && !rst;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr       <= '0;
      lock     <= 1'b0;
      lock_idx <= '0;
    end else begin
      if (accept) rr <= rr_nxt;
      if (gst_bti_req_vld && !gst_bti_req_rdy) begin
        lock     <= 1'b1;
        lock_idx <= win;
      end else begin
        lock <= 1'b0;
      end
    end
  end

  // ------------------------------------------------------------------ ID FIFO
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) &&
                      (wr_ptr[PW-2:0] == rd_ptr[PW-2:0]);
  assign head       = id_mem[rd_ptr[PW-2:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + PW'(1);
      if (pop)    rd_ptr <= rd_ptr + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (accept) id_mem[wr_ptr[PW-2:0]] <= win;
  end

  // ---------------------------------------------------------- response routing
  always_comb begin
    gst_bti_rsp_rdy  = 1'b0;
    host_bti_rsp_vld = '0;
    for (int i = 0; i < HOST_NUM; i++) begin
      if (IW'(i) == head && !fifo_empty && !rst) begin
        gst_bti_rsp_rdy     = host_bti_rsp_rdy[i];
        host_bti_rsp_vld[i] = gst_bti_rsp_vld;
      end
    end
  end

  assign pop = gst_bti_rsp_vld && gst_bti_rsp_rdy;

  generate
    for (genvar g = 0; g < HOST_NUM; g++) begin : g_rsp_data
      assign host_bti_rsp_data[g*BTI_DW +: BTI_DW] = gst_bti_rsp_data;
    end
  endgenerate

endmodule

`default_nettype wire

// File: tb/tb_bti_arbiter.sv
// ============================================================================
// Module   : tb_bti_arbiter
// Brief    : Directed table-driven bench for bti_arbiter (HOST_NUM=2, OUTSTD=4)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bti_arbiter;

  logic        clk;
  logic        rst;
  logic [1:0]  h_req_vld;
  logic [1:0]  h_req_rdy;
  logic [63:0] h_req_addr;
  logic [1:0]  h_req_cmd;
  logic [63:0] h_req_wdata;
  logic [1:0]  h_rsp_vld;
  logic [1:0]  h_rsp_rdy;
  logic [63:0] h_rsp_data;
  logic        g_req_vld;
  logic        g_req_rdy;
  logic [31:0] g_req_addr;
  logic        g_req_cmd;
  logic [31:0] g_req_wdata;
  logic        g_rsp_vld;
  logic        g_rsp_rdy;
  logic [31:0] g_rsp_data;

  int tests = 0;
  int fails = 0;

  bti_arbiter #(
    .BTI_AW(32), .BTI_DW(32), .HOST_NUM(2), .OUTSTD(4)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .host_bti_req_vld  (h_req_vld),
    .host_bti_req_rdy  (h_req_rdy),
    .host_bti_req_addr (h_req_addr),
    .host_bti_req_cmd  (h_req_cmd),
    .host_bti_req_wdata(h_req_wdata),
    .host_bti_rsp_vld  (h_rsp_vld),
    .host_bti_rsp_rdy  (h_rsp_rdy),
    .host_bti_rsp_data (h_rsp_data),
    .gst_bti_req_vld   (g_req_vld),
    .gst_bti_req_rdy   (g_req_rdy),
    .gst_bti_req_addr  (g_req_addr),
    .gst_bti_req_cmd   (g_req_cmd),
    .gst_bti_req_wdata (g_req_wdata),
    .gst_bti_rsp_vld   (g_rsp_vld),
    .gst_bti_rsp_rdy   (g_rsp_rdy),
    .gst_bti_rsp_data  (g_rsp_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  hv;
    logic        grdy;
    logic        rv;
    logic [31:0] rdata;
    logic [1:0]  hrr;
    logic        evld;
    logic [31:0] eaddr;
    logic [1:0]  ehrdy;
    logic [1:0]  ehrv;
    logic        ersprdy;
  } vec_t;

  vec_t tbl [11];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [1:0] hv, input logic grdy, input logic rv,
                       input logic [31:0] rdata, input logic [1:0] hrr);
    h_req_vld  = hv;
    g_req_rdy  = grdy;
    g_rsp_vld  = rv;
    g_rsp_data = rdata;
    h_rsp_rdy  = hrr;
  endtask

  task automatic chk_req(input string nm, input logic evld, input logic [31:0] eaddr,
                         input logic [1:0] ehrdy);
    chk({nm, ".gvld"}, 64'(g_req_vld), 64'(evld));
    if (evld) chk({nm, ".gaddr"}, 64'(g_req_addr), 64'(eaddr));
    chk({nm, ".hrdy"}, 64'(h_req_rdy), 64'(ehrdy));
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, ".gvld"}, 64'(g_req_vld), 64'd0);
    chk({nm, ".hrdy"}, 64'(h_req_rdy), 64'd0);
    chk({nm, ".hrv"},  64'(h_rsp_vld), 64'd0);
    chk({nm, ".grr"},  64'(g_rsp_rdy), 64'd0);
  endtask

  initial begin
    // host0: read 0x100; host1: write 0x200
    h_req_addr  = {32'h0000_0200, 32'h0000_0100};
    h_req_cmd   = 2'b10;
    h_req_wdata = {32'hB0B0_0001, 32'hA0A0_0000};

    //        hv     grdy  rv    rdata  hrr   | evld  eaddr         ehrdy  ehrv   ersprdy
    tbl[0]  = '{2'b11, 1'b1, 1'b0, 32'd0, 2'b11, 1'b1, 32'h100, 2'b01, 2'b00, 1'b0};
    tbl[1]  = '{2'b11, 1'b1, 1'b0, 32'd0, 2'b11, 1'b1, 32'h200, 2'b10, 2'b00, 1'b1};
    tbl[2]  = '{2'b11, 1'b1, 1'b0, 32'd0, 2'b11, 1'b1, 32'h100, 2'b01, 2'b00, 1'b1};
    tbl[3]  = '{2'b11, 1'b1, 1'b0, 32'd0, 2'b11, 1'b1, 32'h200, 2'b10, 2'b00, 1'b1};
    tbl[4]  = '{2'b11, 1'b1, 1'b1, 32'd1, 2'b11, 1'b0, 32'h100, 2'b00, 2'b01, 1'b1};
    tbl[5]  = '{2'b11, 1'b1, 1'b1, 32'd2, 2'b11, 1'b1, 32'h100, 2'b01, 2'b10, 1'b1};
    tbl[6]  = '{2'b00, 1'b1, 1'b1, 32'd3, 2'b11, 1'b0, 32'h200, 2'b00, 2'b01, 1'b1};
    tbl[7]  = '{2'b00, 1'b1, 1'b1, 32'd4, 2'b10, 1'b0, 32'h200, 2'b00, 2'b10, 1'b1};
    tbl[8]  = '{2'b00, 1'b1, 1'b1, 32'd5, 2'b10, 1'b0, 32'h200, 2'b00, 2'b01, 1'b0};
    tbl[9]  = '{2'b00, 1'b1, 1'b1, 32'd6, 2'b01, 1'b0, 32'h200, 2'b00, 2'b01, 1'b1};
    tbl[10] = '{2'b00, 1'b1, 1'b1, 32'd7, 2'b11, 1'b0, 32'h200, 2'b00, 2'b00, 1'b0};

    // reset state with busy hosts and guest
    rst = 1'b1;
    drive(2'b11, 1'b1, 1'b1, 32'h0, 2'b11);
    #2;
    chk_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // fairness, full FIFO, pop-then-push, interleaved response routing
    for (int v = 0; v < 11; v++) begin
      if (v > 0) @(negedge clk);
      drive(tbl[v].hv, tbl[v].grdy, tbl[v].rv, tbl[v].rdata, tbl[v].hrr);
      #1;
      chk($sformatf("v%0d.gvld", v), 64'(g_req_vld), 64'(tbl[v].evld));
      chk($sformatf("v%0d.gaddr", v), 64'(g_req_addr), 64'(tbl[v].eaddr));
      chk($sformatf("v%0d.hrdy", v), 64'(h_req_rdy), 64'(tbl[v].ehrdy));
      chk($sformatf("v%0d.hrv", v), 64'(h_rsp_vld), 64'(tbl[v].ehrv));
      chk($sformatf("v%0d.grr", v), 64'(g_rsp_rdy), 64'(tbl[v].ersprdy));
      if (tbl[v].ehrv != 2'b00)
        chk($sformatf("v%0d.hdata", v), 64'(h_rsp_data), {tbl[v].rdata, tbl[v].rdata});
    end

    // single host read, response one cycle later (rr=1 here)
    @(negedge clk);
    drive(2'b01, 1'b1, 1'b0, 32'h0, 2'b11);
    #1;
    chk_req("single.req", 1'b1, 32'h100, 2'b01);
    chk("single.cmd", 64'(g_req_cmd), 64'd0);
    @(negedge clk);
    drive(2'b00, 1'b1, 1'b1, 32'hDEAD_BEEF, 2'b11);
    #1;
    chk("single.hrv", 64'(h_rsp_vld), 64'b01);
    chk("single.data", 64'(h_rsp_data[31:0]), 64'hDEAD_BEEF);
    chk("single.grr", 64'(g_rsp_rdy), 64'd1);

    // stall lock: host0 held for 3 stalled cycles while host1 (priority) waits
    @(negedge clk);
    drive(2'b01, 1'b0, 1'b0, 32'h0, 2'b11);
    #1;
    chk_req("stall0", 1'b1, 32'h100, 2'b00);
    for (int s = 1; s < 3; s++) begin
      @(negedge clk);
      drive(2'b11, 1'b0, 1'b0, 32'h0, 2'b11);
      #1;
      chk_req($sformatf("stall%0d", s), 1'b1, 32'h100, 2'b00);
    end
    @(negedge clk);
    drive(2'b11, 1'b1, 1'b0, 32'h0, 2'b11);
    #1;
    chk_req("stall.hs", 1'b1, 32'h100, 2'b01);
    @(negedge clk);
    #1;
    chk_req("stall.next", 1'b1, 32'h200, 2'b10);
    chk("stall.cmd", 64'(g_req_cmd), 64'd1);
    chk("stall.wdata", 64'(g_req_wdata), 64'hB0B0_0001);
    @(negedge clk);
    drive(2'b01, 1'b1, 1'b0, 32'h0, 2'b11);
    #1;
    chk_req("pre_rst.req", 1'b1, 32'h100, 2'b01);

    // reset mid-cycle with three outstanding IDs (rr=1 before reset)
    @(negedge clk);
    drive(2'b11, 1'b1, 1'b1, 32'h55, 2'b11);
    #1;
    chk("pre_rst.hrv", 64'(h_rsp_vld), 64'b01);
    #1;
    rst = 1'b1;
    #1;
    chk_zero("mid_rst");
    @(negedge clk);
    chk_zero("hold_rst");
    rst = 1'b0;
    drive(2'b00, 1'b1, 1'b1, 32'h66, 2'b11);
    #1;
    chk("post_rst.hrv", 64'(h_rsp_vld), 64'd0);
    chk("post_rst.grr", 64'(g_rsp_rdy), 64'd0);
    @(negedge clk);
    drive(2'b11, 1'b1, 1'b0, 32'h0, 2'b11);
    #1;
    chk_req("post_rst.rr", 1'b1, 32'h100, 2'b01);

    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bti_arbiter.md
# bti_arbiter

Many-to-one BTI arbiter: merges HOST_NUM BTI initiator ports onto a single BTI guest port, the converging counterpart of the one-to-many address demux. It lets several masters, such as the instruction fetch and data ports or a future DMA, share one slave, such as a unified SRAM or flash. Requests are granted round-robin. A per-request host-ID FIFO routes in-order guest responses back to the originating host.

## Interface
Parameters:
- BTI_AW, 32, request address width
- BTI_DW, 32, data width
- HOST_NUM, 2, number of host ports (2..8)
- OUTSTD, 4, maximum outstanding requests; depth of the ID FIFO (power of 2, ≥2)

Ports (BTI interfaces carry: req vld/rdy/addr[BTI_AW]/cmd (0=read, 1=write)/wdata[BTI_DW]; rsp vld/rdy/data[BTI_DW]):
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  reset, asynchronous, active-high
- host_bti_req_slvs  bti_req_if_t slave  [HOST_NUM]  host requests in
- host_bti_rsp_msts  bti_rsp_if_t master  [HOST_NUM]  responses to hosts
- gst_bti_req_mst  bti_req_if_t master  1  request to guest
- gst_bti_rsp_slv  bti_rsp_if_t slave  1  response from guest

## Operation
- Arbitration is combinational round-robin. A pointer `rr` (reset 0) names the highest-priority host. The first valid host at or after `rr`, with wrap-around modulo HOST_NUM, wins.
- Grant lock: if the guest req has vld=1 and rdy=0, the winner index is registered and held until that handshake completes. No re-arbitration occurs while a request is stalled, so payload and valid stay stable.
- Forwarding: guest req vld/addr/cmd/wdata come from the winner. The winner's req rdy equals guest rdy AND NOT fifo_full. All other hosts see rdy=0.
- Guest req vld is forced to 0 while fifo_full. A request is accepted on guest vld AND rdy.
- On acceptance:
  - push the winner index into the ID FIFO;
  - set `rr` to winner+1 (mod HOST_NUM).
- Response routing:
  - Guest rsp rdy equals the head host's rsp rdy, and is 0 when the FIFO is empty.
  - Only the host at the FIFO head sees rsp vld=guest rsp vld, with data forwarded. All other hosts see vld=0.
  - The head is popped on the guest rsp handshake.
- Same-cycle push and pop are allowed when the FIFO is neither empty nor full; the count is unchanged.
- When full, a push is blocked even if a pop occurs in the same cycle; the request is accepted next cycle at the earliest.
- Pop when empty cannot occur because rsp rdy is 0. A guest rsp vld while empty is a protocol violation and is ignored (no host sees it).
- Write requests also push an ID: the guest returns one response per request, reads and writes alike.
- FIFO: wr/rd pointers of log2(OUTSTD)+1 bits with wrap bit. full = pointers differ only in MSB; empty = pointers equal.

## Timing
- Request path and response path are combinational, with zero added latency.
- rr, lock, and FIFO state update on the rising clk edge following a handshake.
- Reset, asynchronous on rst rising; outputs take these values within the same cycle:
  - rr=0, lock cleared, FIFO empty.
  - All host req rdy=0, host rsp vld=0, guest req vld=0, guest rsp rdy=0.
  - Held at these values while rst=1.
- Reset mid-transaction: outstanding IDs are discarded. The guest must also be reset; late guest responses are ignored because the FIFO is empty.
- Back-to-back: one request per cycle is sustained while the guest rdy=1 and the FIFO is not full.

## Test plan
- Single host: host0 reads addr 0x100 while the guest returns 0xDEADBEEF one cycle later. Host0 gets rsp 0xDEADBEEF; host1 never sees rsp vld.
- Fairness: both hosts hold vld continuously with guest rdy=1. Grants alternate 0,1,0,1 across 8 cycles and the FIFO order matches.
- Stall lock: guest rdy=0 for 3 cycles while host0 is granted and host1 raises vld. The grant stays on host0 and addr is stable. After host0's handshake, host1 is granted next cycle.
- Full: OUTSTD=4 with the guest withholding rsp. After 4 accepts, all host rdy=0 and guest vld=0. One rsp pops, and the 5th request is accepted the cycle after the pop.
- Interleaved responses: hosts issue 0,1,1,0 and the guest responds with data 1,2,3,4 in order. Host0 receives 1 and 4; host1 receives 2 and 3.
- Reset with 2 outstanding: assert rst mid-cycle. All outputs go to 0 immediately; after release, rr=0 and the FIFO is empty.
